lb_frame_ctrl: RTL
==================

Name: lb_frame_ctrl

Overview:
Frame-level sequencer placed in front of the 3x3 line-buffer/window datapath. It accepts an upstream pixel stream with a valid/ready handshake and sof/eol markers, and aligns each frame to start-of-frame. It forwards exactly WIDTH*HEIGHT pixels as in_valid/pix_in to the line buffer, then blocks upstream while the line buffer flushes its bottom padding row. It counts emitted windows to declare frame completion and flags malformed frames.

Parameters:
DATA_WIDTH, 8, pixel width
WIDTH, 640, pixels per line (<=1024)
HEIGHT, 480, lines per frame
DRAIN_CYCLES, 1024, maximum cycles in DRAIN before timeout (must exceed WIDTH+16)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
enable  in  1  allow new frames to start
s_valid  in  1  upstream pixel valid
s_ready  out  1  upstream ready
s_data  in  DATA_WIDTH  upstream pixel
s_sof  in  1  first pixel of frame
s_eol  in  1  last pixel of line
lb_in_valid  out  1  to line buffer in_valid
lb_pix_in  out  DATA_WIDTH  to line buffer pix_in
lb_win_valid  in  1  line buffer win_valid
frame_busy  out  1  state is STREAM or DRAIN
frame_done  out  1  one-cycle completion pulse
err_sof  out  1  sticky: sof seen mid-frame
err_eol  out  1  sticky: eol position mismatch
err_timeout  out  1  sticky: DRAIN timed out
err_clr  in  1  clears all sticky errors

Behaviour:
- Reset: state IDLE. All outputs are 0. x_cnt, y_cnt, win_cnt and drain_cnt are 0.
- Accept condition: beat = s_valid && s_ready.
- s_ready is combinational and equals (state==WAIT_SOF || state==STREAM).
- IDLE: enable=1 -> WAIT_SOF.
- WAIT_SOF:
  - Beats without s_sof are accepted and discarded (not forwarded).
  - A beat with s_sof is forwarded and sets x_cnt=1, y_cnt=0, win_cnt=0 -> STREAM.
  - If WIDTH==1, the sof beat wraps x_cnt to 0 and sets y_cnt=1 instead.
  - enable=0 while in WAIT_SOF -> IDLE.
- STREAM: every beat is forwarded.
  - x_cnt wraps at WIDTH-1 and increments y_cnt.
  - The beat at x_cnt==WIDTH-1 && y_cnt==HEIGHT-1 is the last one -> DRAIN on the same edge, so s_ready falls in the next cycle.
  - Frame geometry comes from the counters only; the markers never change it.
  - s_eol=1 at x_cnt!=WIDTH-1, or s_eol=0 at x_cnt==WIDTH-1 -> err_eol=1.
  - s_sof=1 on any beat -> err_sof=1; the pixel is still forwarded as a normal pixel.
  - enable=0 has no effect until the frame ends.
- Forwarding: lb_in_valid and lb_pix_in are registered, one cycle after the accepting edge. lb_in_valid=0 on cycles with no forwarded beat; lb_pix_in holds its last value.
- win_cnt: increments on every lb_win_valid while in STREAM or DRAIN. Width is $clog2(WIDTH*HEIGHT+1). It saturates at WIDTH*HEIGHT.
- DRAIN:
  - s_ready=0. drain_cnt increments each cycle.
  - win_cnt==WIDTH*HEIGHT -> frame_done=1 for one cycle (registered, the cycle after the count is reached). Next state is WAIT_SOF if enable=1, else IDLE.
  - drain_cnt==DRAIN_CYCLES-1 before completion -> err_timeout=1, frame_done pulses, same exit.
  - drain_cnt clears on exit.
- Sticky errors: err_clr clears all three. A new error event in the same cycle as err_clr wins (flag stays 1).
- Reset mid-frame: returns to IDLE in the next cycle with all outputs 0. A partially loaded line buffer is the line buffer's own reset responsibility.

Optional Feature:
Macro LBC_FRAME_STATS_EN. When defined, adds two outputs:
- frame_cnt (16 bits): increments on each frame_done, wraps at 65535->0.
- drop_cnt (16 bits): counts discarded WAIT_SOF beats, saturates at 65535.
Both reset to 0 and are cleared by err_clr. When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
(All with WIDTH=4, HEIGHT=3, DRAIN_CYCLES=32, behavioural line-buffer model.)
- Clean frame: 12 beats, sof on beat 1, eol on beats 4/8/12 -> 12 lb_in_valid pulses, each 1 cycle after its accept. s_ready=0 from the cycle after beat 12. Model returns 12 win_valid -> frame_done pulses once, all err_*=0.
- Pre-sof garbage: 3 beats without sof, then a clean frame -> the 3 are not forwarded (lb_in_valid stays 0); frame forwards exactly 12. With LBC_FRAME_STATS_EN, drop_cnt=3 and frame_cnt=1.
- Misplaced eol: eol asserted on beat 3 instead of 4 -> err_eol=1 and stays 1. 12 pixels still forwarded, frame_done pulses; err_clr pulse -> err_eol=0.
- Missing windows: model emits only 10 win_valid -> err_timeout=1 after 32 DRAIN cycles, then frame_done pulses and the block returns to WAIT_SOF.
- Reset mid-STREAM after beat 5 -> next cycle state IDLE, s_ready=0, lb_in_valid=0, frame_busy=0. A following frame after enable completes normally.
- enable dropped at beat 6 -> frame completes with 12 forwarded beats and frame_done, then IDLE with s_ready=0. A sof beat offered afterwards is not accepted.

Source files
------------

// File: rtl/lb_frame_ctrl.sv
// Frame sequencer ahead of the 3x3 line-buffer/window datapath: aligns to sof, forwards one frame, waits for the drain.
// Optional frame statistics outputs are compiled in with LBC_FRAME_STATS_EN.
module lb_frame_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int DRAIN_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_eol,
  output logic                  lb_in_valid,
  output logic [DATA_WIDTH-1:0] lb_pix_in,
  input  logic                  lb_win_valid,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic                  err_sof,
  output logic                  err_eol,
  output logic                  err_timeout,
  input  logic                  err_clr
`ifdef LBC_FRAME_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int WW    = $clog2(TOTAL + 1);
  localparam int DW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, STREAM, DRAIN} state_t;

  state_t                 state_reg, state_next;
  logic [XW-1:0]          x_cnt_reg;
  logic [YW-1:0]          y_cnt_reg;
  logic [WW-1:0]          win_cnt_reg;
  logic [DW-1:0]          drain_cnt_reg;
  logic                   lb_in_valid_reg, frame_done_reg;
  logic [DATA_WIDTH-1:0]  lb_pix_reg;
  logic                   err_sof_reg, err_eol_reg, err_timeout_reg;

  logic beat, sof_start, stream_beat, last_beat, fwd;
  logic x_last, y_last, win_full, done_now, timeout_now;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    s_ready     = (state_reg == WAIT_SOF) || (state_reg == STREAM);
    frame_busy  = (state_reg == STREAM) || (state_reg == DRAIN);
    beat        = s_valid && s_ready;
    x_last      = (x_cnt_reg == X_LAST);
    y_last      = (y_cnt_reg == Y_LAST);
    sof_start   = (state_reg == WAIT_SOF) && beat && s_sof;
    stream_beat = (state_reg == STREAM) && beat;
    last_beat   = stream_beat && x_last && y_last;
    fwd         = sof_start || stream_beat;
    win_full    = (win_cnt_reg == WW'(TOTAL));
    done_now    = (state_reg == DRAIN) && win_full;
    timeout_now = (state_reg == DRAIN) && !win_full && (drain_cnt_reg == DW'(DRAIN_CYCLES - 1));
    state_next  = state_reg;
    case (state_reg)
      IDLE:     if (enable) state_next = WAIT_SOF;
      WAIT_SOF: begin
        // A one-pixel frame is complete as soon as its sof beat is taken.
        if (sof_start)   state_next = (TOTAL == 1) ? DRAIN : STREAM;
        else if (!enable) state_next = IDLE;
      end
      STREAM:   if (last_beat) state_next = DRAIN;
      DRAIN:    if (done_now || timeout_now) state_next = enable ? WAIT_SOF : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Geometry comes only from the counters; markers are checked, never obeyed.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt_reg     <= '0;
      y_cnt_reg     <= '0;
      win_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
    end else begin
      if (sof_start) begin
        x_cnt_reg   <= (WIDTH == 1) ? '0 : XW'(1);
        y_cnt_reg   <= (WIDTH == 1) ? YW'(1) : '0;
        win_cnt_reg <= '0;
      end else begin
        if (stream_beat) begin
          if (last_beat) begin
            x_cnt_reg <= '0;
            y_cnt_reg <= '0;
          end else if (x_last) begin
            x_cnt_reg <= '0;
            y_cnt_reg <= y_cnt_reg + YW'(1);
          end else begin
            x_cnt_reg <= x_cnt_reg + XW'(1);
          end
        end
        if (frame_busy && lb_win_valid && !win_full)
          win_cnt_reg <= win_cnt_reg + WW'(1);
      end
      if ((state_reg == DRAIN) && !(done_now || timeout_now))
        drain_cnt_reg <= drain_cnt_reg + DW'(1);
      else
        drain_cnt_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lb_in_valid_reg <= 1'b0;
      lb_pix_reg      <= '0;
      frame_done_reg  <= 1'b0;
      err_sof_reg     <= 1'b0;
      err_eol_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      lb_in_valid_reg <= fwd;
      if (fwd) lb_pix_reg <= s_data;
      frame_done_reg  <= done_now || timeout_now;
      // A fresh error event outranks a simultaneous clear.
      err_sof_reg     <= (stream_beat && s_sof) || (err_sof_reg && !err_clr);
      err_eol_reg     <= (stream_beat && (s_eol != x_last)) || (err_eol_reg && !err_clr);
      err_timeout_reg <= timeout_now || (err_timeout_reg && !err_clr);
    end
  end

  assign lb_in_valid = lb_in_valid_reg;
  assign lb_pix_in   = lb_pix_reg;
  assign frame_done  = frame_done_reg;
  assign err_sof     = err_sof_reg;
  assign err_eol     = err_eol_reg;
  assign err_timeout = err_timeout_reg;

`ifdef LBC_FRAME_STATS_EN
  logic [15:0] frame_cnt_reg, drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      frame_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      if (frame_done_reg) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      if ((state_reg == WAIT_SOF) && beat && !s_sof && (drop_cnt_reg != 16'hFFFF))
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign drop_cnt  = drop_cnt_reg;
`endif

endmodule
